// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating signed multiply-accumulate back end.
// Sums a programmed number of 8-bit signed products, accepted one per cycle
// through a valid/ready handshake, and holds the dot-product on a
// valid/ready output until the consumer takes it.
module mac_accumulator #(
    parameter int ACC_WIDTH = 16,
    parameter int LEN_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [7:0]           product,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state_reg, state_next;
    logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
    logic [LEN_WIDTH-1:0]   remaining_reg, remaining_next;
    logic                   overflow_reg, overflow_next;

    // One guard bit above the accumulator lets the sum be checked for
    // overflow by comparing its top two bits.
    logic [ACC_WIDTH:0]     sum_ext;
    logic                   pos_ovf;
    logic                   neg_ovf;
    logic [ACC_WIDTH-1:0]   sum_sat;

    assign sum_ext = {acc_reg[ACC_WIDTH-1], acc_reg}
                   + {{(ACC_WIDTH-7){product[7]}}, product};
    assign pos_ovf = ~sum_ext[ACC_WIDTH] &  sum_ext[ACC_WIDTH-1];
    assign neg_ovf =  sum_ext[ACC_WIDTH] & ~sum_ext[ACC_WIDTH-1];

    // Clamp to the representable range; otherwise drop the guard bit.
    always_comb begin
        sum_sat = sum_ext[ACC_WIDTH-1:0];
        if (pos_ovf) begin
            sum_sat = ACC_MAX;
        end else if (neg_ovf) begin
            sum_sat = ACC_MIN;
        end
    end

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            remaining_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            remaining_reg <= remaining_next;
            overflow_reg  <= overflow_next;
        end
    end

    // Next-state and datapath update; everything holds unless a state acts.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        remaining_next = remaining_reg;
        overflow_next  = overflow_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    remaining_next = len;
                    acc_next       = '0;
                    overflow_next  = 1'b0;
                    state_next     = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_next       = sum_sat;
                    overflow_next  = overflow_reg | pos_ovf | neg_ovf;
                    remaining_next = remaining_reg - LEN_WIDTH'(1);
                    if (remaining_reg == LEN_WIDTH'(1)) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A start arriving with the handshake is deliberately dropped:
                // the new run can only be sampled once IDLE is reached.
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decode purely from the state register.
    assign in_ready  = (state_reg == S_ACCUM);
    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg != S_IDLE);
    assign acc_out   = acc_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: drives two instances (16-bit and 9-bit accumulators)
// with the same directed vectors; expected results go into per-instance
// queues and a negedge monitor compares them whenever out_valid is high.
module tb_mac_accumulator;

    localparam int P_IN_READY  = 0;
    localparam int P_OUT_VALID = 1;
    localparam int P_BUSY      = 2;
    localparam int P_ACC16     = 3;
    localparam int P_OVF16     = 4;
    localparam int P_ACC9      = 5;
    localparam int P_OVF9      = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic [7:0]  product;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready16, out_valid16, overflow16, busy16;
    logic [15:0] acc16;
    logic        in_ready9, out_valid9, overflow9, busy9;
    logic [8:0]  acc9;

    int errors = 0;
    int checks = 0;
    bit stim_done = 1'b0;

    typedef struct {
        logic [15:0] acc;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          sig;
        logic [15:0] val;
        string       name;
    } probe_t;

    exp_t   q16[$];
    exp_t   q9[$];
    probe_t probe_q[$];

    always #5 clk = ~clk;

    mac_accumulator #(.ACC_WIDTH(16), .LEN_WIDTH(4)) dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len), .product(product),
        .in_valid(in_valid), .in_ready(in_ready16), .acc_out(acc16),
        .out_valid(out_valid16), .out_ready(out_ready),
        .overflow(overflow16), .busy(busy16)
    );

    mac_accumulator #(.ACC_WIDTH(9), .LEN_WIDTH(4)) dut9 (
        .clk(clk), .rst(rst), .start(start), .len(len), .product(product),
        .in_valid(in_valid), .in_ready(in_ready9), .acc_out(acc9),
        .out_valid(out_valid9), .out_ready(out_ready),
        .overflow(overflow9), .busy(busy9)
    );

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endfunction

    // Monitor: resolves probes and scoreboard entries on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (probe_q.size() > 0) begin
                probe_t      p;
                logic [15:0] act;
                p = probe_q.pop_front();
                case (p.sig)
                    P_IN_READY:  act = {15'b0, in_ready16};
                    P_OUT_VALID: act = {15'b0, out_valid16};
                    P_BUSY:      act = {15'b0, busy16};
                    P_ACC16:     act = acc16;
                    P_OVF16:     act = {15'b0, overflow16};
                    P_ACC9:      act = {7'b0, acc9};
                    default:     act = {15'b0, overflow9};
                endcase
                check(p.name, act, p.val);
            end
            if (out_valid16) begin
                if (q16.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result16: got acc 0x%h with no result expected", acc16);
                end else begin
                    check("result16_acc", acc16, q16[0].acc);
                    check("result16_ovf", {15'b0, overflow16}, {15'b0, q16[0].ovf});
                    if (out_ready) void'(q16.pop_front());
                end
            end
            if (out_valid9) begin
                if (q9.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result9: got acc 0x%h with no result expected", acc9);
                end else begin
                    check("result9_acc", {7'b0, acc9}, q9[0].acc);
                    check("result9_ovf", {15'b0, overflow9}, {15'b0, q9[0].ovf});
                    if (out_ready) void'(q9.pop_front());
                end
            end
            if (stim_done && probe_q.size() == 0) begin
                check("pending16", 16'(q16.size()), 16'd0);
                check("pending9", 16'(q9.size()), 16'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    // Hard bound on the whole run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int sig, input logic [15:0] val, input string name);
        probe_t p;
        p.sig  = sig;
        p.val  = val;
        p.name = name;
        probe_q.push_back(p);
    endtask

    task automatic expect_result(input logic [15:0] a16, input logic o16,
                                 input logic [15:0] a9, input logic o9);
        exp_t e;
        e.acc = a16; e.ovf = o16; q16.push_back(e);
        e.acc = a9;  e.ovf = o9;  q9.push_back(e);
    endtask

    // Back-to-back run with immediate result acceptance.
    task automatic run(input logic [3:0] n, input logic [7:0] pv[$]);
        step();
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
        len   = 4'h7;
        probe(P_BUSY, 16'd1, "busy_after_start");
        probe(P_OVF16, 16'd0, "ovf16_clear_on_start");
        probe(P_OVF9, 16'd0, "ovf9_clear_on_start");
        if (n != 4'd0) begin
            probe(P_IN_READY, 16'd1, "in_ready_after_start");
        end else begin
            probe(P_IN_READY, 16'd0, "in_ready_zero_len");
            probe(P_OUT_VALID, 16'd1, "out_valid_zero_len");
        end
        for (int i = 0; i < int'(n); i++) begin
            probe(P_OUT_VALID, 16'd0, "out_valid_early");
            in_valid = 1'b1;
            product  = pv[i];
            step();
        end
        in_valid = 1'b0;
        product  = 8'h00;
        probe(P_OUT_VALID, 16'd1, "out_valid_done");
        probe(P_IN_READY, 16'd0, "in_ready_done");
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        probe(P_OUT_VALID, 16'd0, "out_valid_idle");
        probe(P_BUSY, 16'd0, "busy_idle");
    endtask

    initial begin
        logic [7:0] pv[$];
        rst = 1'b1; start = 1'b0; len = 4'd0; product = 8'h00;
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset state after two reset cycles
        step();
        step();
        rst = 1'b0;
        probe(P_IN_READY, 16'd0, "reset_in_ready");
        probe(P_OUT_VALID, 16'd0, "reset_out_valid");
        probe(P_BUSY, 16'd0, "reset_busy");
        probe(P_ACC16, 16'h0000, "reset_acc16");
        probe(P_OVF16, 16'd0, "reset_ovf16");
        probe(P_ACC9, 16'h0000, "reset_acc9");

        // Basic run: 64 - 56 + 7 = 15
        expect_result(16'h000F, 1'b0, 16'h000F, 1'b0);
        pv = '{8'h40, 8'hC8, 8'h07};
        run(4'd3, pv);
        probe(P_ACC16, 16'h000F, "acc_held_in_idle");

        // Stalls and backpressure: -8 + -8 = -16
        expect_result(16'hFFF0, 1'b0, 16'h01F0, 1'b0);
        step(); start = 1'b1; len = 4'd2;
        step(); start = 1'b0; in_valid = 1'b1; product = 8'hF8;
        step(); in_valid = 1'b0; product = 8'h55;
        step(); probe(P_IN_READY, 16'd1, "stall_in_ready");
                probe(P_OUT_VALID, 16'd0, "stall_out_valid");
        step();
        step(); in_valid = 1'b1; product = 8'hF8;
        step(); in_valid = 1'b0; probe(P_OUT_VALID, 16'd1, "stall_done");
        repeat (5) begin
            step();
            probe(P_OUT_VALID, 16'd1, "backpressure_valid");
            probe(P_ACC16, 16'hFFF0, "backpressure_acc");
        end
        out_ready = 1'b1;
        step(); out_ready = 1'b0;
        probe(P_OUT_VALID, 16'd0, "backpressure_release");
        probe(P_BUSY, 16'd0, "backpressure_idle");

        // Zero length
        expect_result(16'h0000, 1'b0, 16'h0000, 1'b0);
        pv = '{};
        run(4'd0, pv);

        // Positive saturation (9-bit clamps at +255)
        expect_result(16'h0140, 1'b0, 16'h00FF, 1'b1);
        pv = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        run(4'd5, pv);
        probe(P_OVF9, 16'd1, "ovf9_sticky_idle");
        probe(P_ACC9, 16'h00FF, "acc9_held_idle");

        // Negative saturation then recovery from the clamped value
        expect_result(16'hFF28, 1'b0, 16'h0140, 1'b1);
        pv = '{8'hC8, 8'hC8, 8'hC8, 8'hC8, 8'hC8, 8'h40};
        run(4'd6, pv);
        probe(P_OVF9, 16'd1, "ovf9_sticky_neg");

        // In-range run after saturation
        expect_result(16'h000E, 1'b0, 16'h000E, 1'b0);
        pv = '{8'h07, 8'h07};
        run(4'd2, pv);

        // Ignored start during ACCUM and during the DONE handshake
        expect_result(16'h0020, 1'b0, 16'h0020, 1'b0);
        step(); start = 1'b1; len = 4'd2;
        step(); start = 1'b1; len = 4'd7; in_valid = 1'b1; product = 8'h10;
        step(); start = 1'b0; product = 8'h10;
        step(); probe(P_OUT_VALID, 16'd1, "ignored_start_len");
                out_ready = 1'b1; start = 1'b1; len = 4'd7;
        step(); start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
                probe(P_OUT_VALID, 16'd0, "handshake_start_valid");
                probe(P_BUSY, 16'd0, "handshake_start_busy");
                probe(P_ACC16, 16'h0020, "done_ignores_product");
        step(); probe(P_BUSY, 16'd0, "no_new_run");
                probe(P_IN_READY, 16'd0, "no_new_run_ready");

        // Reset in the middle of a run
        step(); start = 1'b1; len = 4'd5;
        step(); start = 1'b0; in_valid = 1'b1; product = 8'h40;
        step();
        step(); rst = 1'b1;
        step();
        step(); rst = 1'b0; in_valid = 1'b0;
        probe(P_IN_READY, 16'd0, "midrun_reset_in_ready");
        probe(P_OUT_VALID, 16'd0, "midrun_reset_out_valid");
        probe(P_BUSY, 16'd0, "midrun_reset_busy");
        probe(P_ACC16, 16'h0000, "midrun_reset_acc16");
        probe(P_OVF16, 16'd0, "midrun_reset_ovf16");
        probe(P_ACC9, 16'h0000, "midrun_reset_acc9");

        // Recovery run: single term of -127
        expect_result(16'hFF81, 1'b0, 16'h0181, 1'b0);
        pv = '{8'h81};
        run(4'd1, pv);

        step();
        stim_done = 1'b1;
    end

endmodule
